// File: rtl/resolution_overlay.sv
// resolution_overlay: keys a scaled 16x80 char-ROM text box over a video stream, 3-cycle latency
// Ports: clock/reset_n (async active-low); enable (sampled at frame start); hcount/vcount/de_in/rgb_in
// video in; rom_addr/rom_q char ROM row read (1-cycle registered ROM); de_out/rgb_out/in_box video out.
// Build option: define RES_OVERLAY_BG_EN to fill unset box pixels with BG_RGB instead of rgb_in.
module resolution_overlay #(
  parameter int          POS_X      = 12,
  parameter int          POS_Y      = 12,
  parameter int          SCALE_LOG2 = 1,
  parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB     = 24'h000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  input  logic        de_in,
  input  logic [23:0] rgb_in,
  output logic [3:0]  rom_addr,
  input  logic [79:0] rom_q,
  output logic        de_out,
  output logic [23:0] rgb_out,
  output logic        in_box
);
  typedef enum logic [1:0] {OFF, ARM, ON, DRAIN} state_e;
  state_e state_q, state_d;
  logic [12:0] row_off, col_off;
  logic y_in, x_in, frame_start, pix, box;
  logic [11:0] hcount_d1_q;
  logic [23:0] rgb_d1_q, rgb_d2_q, rgb_out_q, box_rgb;
  logic de_d1_q, de_d2_q, de_out_q, y_d1_q, y_d2_q, on_d1_q, on_d2_q, x_q, in_box_q;
  logic [6:0] col_q;
  logic [3:0] rom_addr_q;
  assign frame_start = de_in && hcount == '0 && vcount == '0;
  assign row_off = {1'b0, vcount} - 13'(POS_Y);
  assign y_in = !row_off[12] && row_off[11:0] < 12'(16 << SCALE_LOG2);
  assign col_off = {1'b0, hcount_d1_q} - 13'(POS_X);
  assign x_in = !col_off[12] && col_off[11:0] < 12'(80 << SCALE_LOG2);
  assign box = on_d2_q && y_d2_q && x_q && de_d2_q;
  // col_q is forced to 0 outside the box so the index stays within 0..79
  assign pix = rom_q[7'd79 - col_q];
`ifdef RES_OVERLAY_BG_EN
  assign box_rgb = BG_RGB;
`else
  assign box_rgb = rgb_d2_q;
`endif
  // Overlay state only moves on/off at frame start so a frame is never torn
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     state_d = enable ? ARM : OFF;
      ARM:     state_d = !enable ? OFF : frame_start ? ON : ARM;
      ON:      state_d = enable ? ON : DRAIN;
      DRAIN:   state_d = enable ? ON : frame_start ? OFF : DRAIN;
      default: state_d = OFF;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= OFF;
      rom_addr_q  <= '0;
      hcount_d1_q <= '0;
      rgb_d1_q    <= '0;
      rgb_d2_q    <= '0;
      rgb_out_q   <= '0;
      de_d1_q     <= 1'b0;
      de_d2_q     <= 1'b0;
      de_out_q    <= 1'b0;
      y_d1_q      <= 1'b0;
      y_d2_q      <= 1'b0;
      on_d1_q     <= 1'b0;
      on_d2_q     <= 1'b0;
      x_q         <= 1'b0;
      col_q       <= '0;
      in_box_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Carry "on" with the pixel so the state change at (0,0) applies exactly from that pixel
      on_d1_q     <= state_d == ON || state_d == DRAIN;
      rom_addr_q  <= de_in && y_in ? 4'(row_off[11:0] >> SCALE_LOG2) : rom_addr_q;
      hcount_d1_q <= hcount;
      rgb_d1_q    <= rgb_in;
      de_d1_q     <= de_in;
      y_d1_q      <= y_in;
      rgb_d2_q    <= rgb_d1_q;
      de_d2_q     <= de_d1_q;
      y_d2_q      <= y_d1_q;
      on_d2_q     <= on_d1_q;
      x_q         <= x_in;
      col_q       <= x_in ? 7'(col_off[11:0] >> SCALE_LOG2) : '0;
      de_out_q    <= de_d2_q;
      in_box_q    <= box;
      rgb_out_q   <= box ? (pix ? FG_RGB : box_rgb) : rgb_d2_q;
    end
  end
  assign rom_addr = rom_addr_q;
  assign de_out   = de_out_q;
  assign rgb_out  = rgb_out_q;
  assign in_box   = in_box_q;
endmodule

// File: tb/tb_resolution_overlay.sv
// tb_resolution_overlay: directed checks of the resolution text overlay
module tb_resolution_overlay;
  localparam int W = 180;
  localparam int NPX = 184;
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h102030;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic de_in = 1'b0;
  logic [11:0] hcount = '0;
  logic [11:0] vcount = '0;
  logic [23:0] rgb_in = '0;
  logic [3:0] rom_addr;
  logic [79:0] rom_q = '0;
  logic de_out, in_box;
  logic [23:0] rgb_out;
  bit zero_rom = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int ea = 0;
  int lv[6] = '{0, 11, 12, 13, 43, 44};
  logic [25:0] xp[3];
  logic [25:0] obs[NPX];
  logic [25:0] exv[NPX];

  resolution_overlay #(.POS_X(12), .POS_Y(12), .SCALE_LOG2(1), .FG_RGB(FG), .BG_RGB(BG)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .hcount(hcount), .vcount(vcount),
    .de_in(de_in), .rgb_in(rgb_in), .rom_addr(rom_addr), .rom_q(rom_q),
    .de_out(de_out), .rgb_out(rgb_out), .in_box(in_box)
  );

  always #5 clock = ~clock;
  // Registered char ROM: every row has its leftmost bit set and its row number in the last 4 bits
  always @(posedge clock) rom_q <= zero_rom ? '0 : {1'b1, 75'b0, rom_addr};

  function automatic logic [25:0] expect_px(int h, int v, logic de, logic [23:0] rgb, bit e);
    int row = (v - 12) / 2;
    int col = (h - 12) / 2;
    logic [3:0] r4 = 4'(row);
    bit box = e && de && v >= 12 && v <= 43 && h >= 12 && h <= 171;
    bit b = !zero_rom && (col == 0 || (col >= 76 && r4[79 - col]));
    logic [23:0] bg;
`ifdef RES_OVERLAY_BG_EN
    bg = BG;
`else
    bg = rgb;
`endif
    return {de, box, box && b ? FG : box ? bg : rgb};
  endfunction

  task automatic px(int h, int v, bit e);
    de_in = h < W;
    hcount = 12'(h);
    vcount = 12'(v);
    rgb_in = de_in ? {8'(h), 8'(v), 8'hA5} : 24'h5A5A5A;
    xp[2] = xp[1];
    xp[1] = xp[0];
    xp[0] = expect_px(h, v, de_in, rgb_in, e);
    @(posedge clock);
    #1;
  endtask

  task automatic drive_line(int v, bit e);
    for (int i = 0; i < NPX; i++) begin
      px(i, v, e);
      obs[i] = {de_out, in_box, rgb_out};
      exv[i] = xp[2];
    end
    if (v >= 12 && v <= 43) ea = (v - 12) / 2;
  endtask

  task automatic test_reset;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      px(i, 12, 1'b0);
      vectors++;
      if ({rom_addr, de_out, in_box, rgb_out} !== 30'd0) begin
        miscompares++;
        $display("FAIL reset i=%0d addr=%0d de=%b box=%b rgb=%h, wanted all zero", i, rom_addr, de_out, in_box, rgb_out);
      end
    end
    enable = 1'b0;
    reset_n = 1'b1;
    xp = '{default: '0};
    ea = 0;
  endtask

  task automatic test_enable_midframe;
    for (int f = 0; f < 2; f++)
      for (int l = 0; l < 6; l++) begin
        if (f == 0 && l == 1) enable = 1'b1;
        drive_line(lv[l], f == 1);
        for (int i = 0; i < NPX; i++) begin
          vectors++;
          if (obs[i] !== exv[i]) begin
            miscompares++;
            $display("FAIL enable f=%0d v=%0d i=%0d {de,box,rgb} got %h want %h", f, lv[l], i, obs[i], exv[i]);
          end
        end
        vectors++;
        if (rom_addr !== 4'(ea)) begin
          miscompares++;
          $display("FAIL enable_addr v=%0d got %0d want %0d", lv[l], rom_addr, ea);
        end
      end
  endtask

  task automatic test_disable_midframe;
    for (int f = 0; f < 3; f++)
      for (int l = 0; l < 6; l++) begin
        if (f == 0 && l == 1) enable = 1'b0;
        if (f == 0 && l == 3) enable = 1'b1;
        if (f == 1 && l == 2) enable = 1'b0;
        drive_line(lv[l], f < 2);
        for (int i = 0; i < NPX; i++) begin
          vectors++;
          if (obs[i] !== exv[i]) begin
            miscompares++;
            $display("FAIL disable f=%0d v=%0d i=%0d {de,box,rgb} got %h want %h", f, lv[l], i, obs[i], exv[i]);
          end
        end
        vectors++;
        if (rom_addr !== 4'(ea)) begin
          miscompares++;
          $display("FAIL disable_addr v=%0d got %0d want %0d", lv[l], rom_addr, ea);
        end
      end
  endtask

  task automatic test_reset_midframe;
    enable = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int l = 0; l < 6; l++) begin
        if (f == 1 && l == 3) begin
          reset_n = 1'b0;
          #1;
          for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({rom_addr, de_out, in_box, rgb_out} !== 30'd0) begin
              miscompares++;
              $display("FAIL reset_mid i=%0d addr=%0d de=%b box=%b rgb=%h, wanted all zero", i, rom_addr, de_out, in_box, rgb_out);
            end
            px(i, 13, 1'b0);
          end
          reset_n = 1'b1;
          xp = '{default: '0};
          ea = 0;
        end
        drive_line(lv[l], f == 2 || (f == 1 && l < 3));
        for (int i = 0; i < NPX; i++) begin
          vectors++;
          if (obs[i] !== exv[i]) begin
            miscompares++;
            $display("FAIL reset_mid f=%0d v=%0d i=%0d {de,box,rgb} got %h want %h", f, lv[l], i, obs[i], exv[i]);
          end
        end
        vectors++;
        if (rom_addr !== 4'(ea)) begin
          miscompares++;
          $display("FAIL reset_mid_addr v=%0d got %0d want %0d", lv[l], rom_addr, ea);
        end
      end
  endtask

  task automatic test_bg;
    zero_rom = 1'b1;
    for (int l = 0; l < 6; l++) begin
      drive_line(lv[l], 1'b1);
      for (int i = 0; i < NPX; i++) begin
        vectors++;
        if (obs[i] !== exv[i]) begin
          miscompares++;
          $display("FAIL bg v=%0d i=%0d {de,box,rgb} got %h want %h", lv[l], i, obs[i], exv[i]);
        end
      end
    end
    zero_rom = 1'b0;
  endtask

  initial begin
    xp = '{default: '0};
    #2;
    test_reset;
    test_enable_midframe;
    test_disable_midframe;
    test_reset_midframe;
    test_bg;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
